toggle_tracker: RTL and testbench
=================================

TOGGLE_TRACKER -- requirements
Module: toggle_tracker

Interface
REQ-001 Parameter WIDTH, default 4: number of monitored channels, 1..32.
REQ-002 Parameter DEPTH, default 4: event FIFO entries; power of two, >= 2.
REQ-003 Parameter CNT_W, default 8: per-channel toggle counter width, 2..16.
REQ-004 Parameter INVERT, default 0: 1 = output b is the inverted registered input.
REQ-005 clk  input  1  single clock; all state updates on the rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 a  input  WIDTH  monitored channel inputs, synchronous to clk.
REQ-008 b  output  WIDTH  registered (optionally inverted) copy of a.
REQ-009 clr  input  1  synchronous clear of counters and overflow flag.
REQ-010 evt_valid  output  1  FIFO head holds a valid change mask.
REQ-011 evt_ready  input  1  consumer accepts the head entry.
REQ-012 evt_mask  output  WIDTH  head change mask; one bit per toggled channel.
REQ-013 evt_level  output  log2(DEPTH)+1  current FIFO occupancy.
REQ-014 overflow  output  1  sticky flag: at least one event was dropped.
REQ-015 cnt_flat  output  WIDTH*CNT_W  counters; channel i at bits [i*CNT_W +: CNT_W].

Function
REQ-016 a_q SHALL capture a every cycle; b SHALL equal a_q XOR {WIDTH{INVERT}}; latency 1 cycle.
REQ-017 change SHALL equal a XOR a_q, evaluated in the same cycle that a_q is loaded.
REQ-018 A non-zero change SHALL be pushed to the FIFO at that edge; an all-zero change SHALL NOT be pushed.
REQ-019 A pushed entry SHALL drive evt_valid high in the cycle after the push edge (registered FIFO, no fall-through).
REQ-020 Pop SHALL occur on an edge where evt_valid and evt_ready are both high; evt_ready while evt_valid is low SHALL have no effect.
REQ-021 evt_mask SHALL hold stable while evt_valid is high and evt_ready is low.
REQ-022 Push when full without a same-cycle pop SHALL drop the entry, set overflow, and leave FIFO contents unchanged.
REQ-023 Push and pop in the same cycle while full SHALL succeed; occupancy stays DEPTH and overflow is not set.
REQ-024 Push and pop in the same cycle while empty SHALL be impossible (no fall-through); the push SHALL succeed.
REQ-025 FIFO pointers SHALL wrap modulo DEPTH; evt_level SHALL equal pushes minus pops, range 0..DEPTH.
REQ-026 Counter i SHALL increment by 1 on each edge where change[i]=1, saturating at 2^CNT_W-1.
REQ-027 clr SHALL zero all counters and overflow at the next edge; clr wins over a same-cycle increment or overflow set.
REQ-028 clr SHALL NOT affect FIFO contents, a_q or b.

Reset
REQ-029 When rst=1 at an edge: a_q=0, b={WIDTH{INVERT}}, FIFO empty, evt_valid=0, evt_level=0, overflow=0, counters=0.
REQ-030 rst SHALL take priority over clr, push and pop; the first cycle after rst deasserts compares a against a_q=0.

Configuration
REQ-031 Macro TOGGLE_TRACKER_COUNT_EN defined: counters and cnt_flat are implemented per REQ-026/027.
REQ-032 Macro TOGGLE_TRACKER_COUNT_EN undefined: no counter flops; cnt_flat ties to 0; clr clears overflow only.

Structure
REQ-033 Package toggle_tracker_pkg SHALL hold the default WIDTH/DEPTH/CNT_W values and a function computing the evt_level width.
REQ-034 The FIFO SHALL be a separate sub-module, event_fifo (parameters WIDTH, DEPTH), instantiated once.

Verification
REQ-035 Reset, then a=4'b0000 -> 4'b0101 -> b=4'b0101 one edge later; evt_valid=1, evt_mask=4'b0101 the following cycle.
REQ-036 INVERT=1, a held at 4'b0011 -> b=4'b1100; a single initial event with mask 4'b0011, then no further events.
REQ-037 evt_ready=0, five distinct toggles, DEPTH=4 -> evt_level=4, overflow=1, four oldest masks popped in order.
REQ-038 FIFO full, toggle with evt_ready=1 in the same cycle -> evt_level stays 4, overflow stays 0.
REQ-039 CNT_W=2, channel 0 toggles 5 times -> counter 0 = 3 (saturated); clr pulse concurrent with a toggle -> counter 0 = 0.
REQ-040 rst asserted with 2 entries queued and counters non-zero -> next cycle evt_valid=0, evt_level=0, cnt_flat=0.

Source files
------------

// File: rtl/toggle_tracker_pkg.sv
// Shared defaults and helpers for the toggle tracker.
// Optional per-channel counters are enabled by defining TOGGLE_TRACKER_COUNT_EN.
package toggle_tracker_pkg;

   localparam int DEFAULT_WIDTH = 4;
   localparam int DEFAULT_DEPTH = 4;
   localparam int DEFAULT_CNT_W = 8;

   // Occupancy must represent 0..DEPTH inclusive, hence one bit above the pointer width.
   function automatic int level_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/event_fifo.sv
// Registered event FIFO holding channel change masks; no fall-through.
// A push while full is dropped unless a pop happens on the same edge.
module event_fifo
   import toggle_tracker_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int DEPTH = DEFAULT_DEPTH
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            push,
   input  logic [WIDTH-1:0]                push_data,
   input  logic                            ready,
   output logic                            valid,
   output logic [WIDTH-1:0]                head,
   output logic [level_width(DEPTH)-1:0]   level,
   output logic                            drop
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = level_width(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [LVL_W-1:0] count_q, count_d;
   logic             full;
   logic             pop;
   logic             do_push;

   assign valid = (count_q != '0);
   assign head  = mem_q[rd_ptr_q];
   assign level = count_q;

   // When full, a same-edge pop frees the slot the write pointer already aims at.
   always_comb begin
      full     = (count_q == LVL_W'(DEPTH));
      pop      = valid & ready;
      do_push  = push & (~full | pop);
      drop     = push & full & ~pop;
      mem_d    = mem_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = push_data;
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({do_push, pop})
         2'b10:   count_d = count_q + LVL_W'(1);
         2'b01:   count_d = count_q - LVL_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         mem_q    <= mem_d;
      end
   end

endmodule

// File: rtl/toggle_tracker.sv
// Registers monitored channels, queues per-cycle change masks and flags drops.
// Define TOGGLE_TRACKER_COUNT_EN to build the saturating per-channel toggle counters.
module toggle_tracker
   import toggle_tracker_pkg::*;
#(
   parameter int WIDTH  = DEFAULT_WIDTH,
   parameter int DEPTH  = DEFAULT_DEPTH,
   parameter int CNT_W  = DEFAULT_CNT_W,
   parameter int INVERT = 0
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [WIDTH-1:0]                a,
   output logic [WIDTH-1:0]                b,
   input  logic                            clr,
   output logic                            evt_valid,
   input  logic                            evt_ready,
   output logic [WIDTH-1:0]                evt_mask,
   output logic [level_width(DEPTH)-1:0]   evt_level,
   output logic                            overflow,
   output logic [WIDTH*CNT_W-1:0]          cnt_flat
);

   localparam logic [WIDTH-1:0] INV_MASK = (INVERT != 0) ? '1 : '0;

   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] change;
   logic             overflow_q, overflow_d;
   logic             drop;

   assign b        = a_q ^ INV_MASK;
   assign overflow = overflow_q;

   // clr outranks a drop landing on the same edge.
   always_comb begin
      a_d        = a;
      change     = a ^ a_q;
      overflow_d = overflow_q;
      if (clr) begin
         overflow_d = 1'b0;
      end else if (drop) begin
         overflow_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_q        <= '0;
         overflow_q <= 1'b0;
      end else begin
         a_q        <= a_d;
         overflow_q <= overflow_d;
      end
   end

   event_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (|change),
      .push_data (change),
      .ready     (evt_ready),
      .valid     (evt_valid),
      .head      (evt_mask),
      .level     (evt_level),
      .drop      (drop)
   );

`ifdef TOGGLE_TRACKER_COUNT_EN
   logic [CNT_W-1:0] cnt_q [WIDTH];
   logic [CNT_W-1:0] cnt_d [WIDTH];

   // Counters stick at all-ones rather than wrapping.
   always_comb begin
      for (int i = 0; i < WIDTH; i++) begin
         cnt_d[i] = cnt_q[i];
         if (clr) begin
            cnt_d[i] = '0;
         end else if (change[i] && (cnt_q[i] != '1)) begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < WIDTH; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         cnt_q <= cnt_d;
      end
   end

   for (genvar g = 0; g < WIDTH; g++) begin : g_cnt
      assign cnt_flat[g*CNT_W +: CNT_W] = cnt_q[g];
   end
`else
   assign cnt_flat = '0;
`endif

endmodule

// File: tb/tb_toggle_tracker.sv
// Self-checking bench for toggle_tracker: vector table plus directed multi-cycle sequences.
module tb_toggle_tracker;

   typedef struct {
      logic       rst;
      logic       clr;
      logic       ready;
      logic [3:0] a;
      logic [3:0] exp_b;
      logic       exp_valid;
      logic [3:0] exp_mask;
      logic [2:0] exp_level;
      logic       exp_ovf;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       clr = 1'b0;
   logic       evt_ready = 1'b0;
   logic [3:0] a = 4'h0;
   logic [3:0] b;
   logic       evt_valid;
   logic [3:0] evt_mask;
   logic [2:0] evt_level;
   logic       overflow;
   logic [7:0] cnt_flat;

   logic       rst_i = 1'b1;
   logic       ready_i = 1'b0;
   logic [3:0] a_i = 4'h0;
   logic [3:0] b_i;
   logic       valid_i;
   logic [3:0] mask_i;
   logic [2:0] level_i;
   logic       ovf_i;
   logic [7:0] cnt_i;

   int tests = 0;
   int failures = 0;
   vec_t vecs [22];

   always #5 clk = ~clk;

   toggle_tracker #(.WIDTH(4), .DEPTH(4), .CNT_W(2), .INVERT(0)) dut (
      .clk(clk), .rst(rst), .a(a), .b(b), .clr(clr),
      .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_mask(evt_mask),
      .evt_level(evt_level), .overflow(overflow), .cnt_flat(cnt_flat)
   );

   toggle_tracker #(.WIDTH(4), .DEPTH(4), .CNT_W(2), .INVERT(1)) dut_inv (
      .clk(clk), .rst(rst_i), .a(a_i), .b(b_i), .clr(1'b0),
      .evt_valid(valid_i), .evt_ready(ready_i), .evt_mask(mask_i),
      .evt_level(level_i), .overflow(ovf_i), .cnt_flat(cnt_i)
   );

   function automatic logic [7:0] expCnt(input logic [7:0] v);
`ifdef TOGGLE_TRACKER_COUNT_EN
      return v;
`else
      return 8'h00;
`endif
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic r, input logic c, input logic rdy, input logic [3:0] av);
      rst       = r;
      clr       = c;
      evt_ready = rdy;
      a         = av;
      tick();
   endtask

   task automatic checkOutput(input string name, input int unsigned actual, input int unsigned expected);
      tests++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   initial begin
      // rst clr rdy a | b valid mask level ovf
      vecs[0]  = '{1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 3'd0, 1'b0};
      vecs[1]  = '{1'b0, 1'b0, 1'b0, 4'b0101, 4'b0101, 1'b1, 4'b0101, 3'd1, 1'b0};
      vecs[2]  = '{1'b0, 1'b0, 1'b1, 4'b0101, 4'b0101, 1'b0, 4'b0000, 3'd0, 1'b0};
      vecs[3]  = '{1'b0, 1'b0, 1'b0, 4'b0100, 4'b0100, 1'b1, 4'b0001, 3'd1, 1'b0};
      vecs[4]  = '{1'b0, 1'b0, 1'b0, 4'b0110, 4'b0110, 1'b1, 4'b0001, 3'd2, 1'b0};
      vecs[5]  = '{1'b0, 1'b0, 1'b0, 4'b1110, 4'b1110, 1'b1, 4'b0001, 3'd3, 1'b0};
      vecs[6]  = '{1'b0, 1'b0, 1'b0, 4'b1010, 4'b1010, 1'b1, 4'b0001, 3'd4, 1'b0};
      vecs[7]  = '{1'b0, 1'b0, 1'b0, 4'b1011, 4'b1011, 1'b1, 4'b0001, 3'd4, 1'b1};
      vecs[8]  = '{1'b0, 1'b0, 1'b1, 4'b1011, 4'b1011, 1'b1, 4'b0010, 3'd3, 1'b1};
      vecs[9]  = '{1'b0, 1'b0, 1'b1, 4'b1011, 4'b1011, 1'b1, 4'b1000, 3'd2, 1'b1};
      vecs[10] = '{1'b0, 1'b0, 1'b1, 4'b1011, 4'b1011, 1'b1, 4'b0100, 3'd1, 1'b1};
      vecs[11] = '{1'b0, 1'b0, 1'b1, 4'b1011, 4'b1011, 1'b0, 4'b0000, 3'd0, 1'b1};
      vecs[12] = '{1'b0, 1'b1, 1'b0, 4'b1011, 4'b1011, 1'b0, 4'b0000, 3'd0, 1'b0};
      vecs[13] = '{1'b0, 1'b0, 1'b0, 4'b1010, 4'b1010, 1'b1, 4'b0001, 3'd1, 1'b0};
      vecs[14] = '{1'b0, 1'b0, 1'b0, 4'b1000, 4'b1000, 1'b1, 4'b0001, 3'd2, 1'b0};
      vecs[15] = '{1'b0, 1'b0, 1'b0, 4'b1100, 4'b1100, 1'b1, 4'b0001, 3'd3, 1'b0};
      vecs[16] = '{1'b0, 1'b0, 1'b0, 4'b0100, 4'b0100, 1'b1, 4'b0001, 3'd4, 1'b0};
      vecs[17] = '{1'b0, 1'b0, 1'b1, 4'b0101, 4'b0101, 1'b1, 4'b0010, 3'd4, 1'b0};
      vecs[18] = '{1'b0, 1'b0, 1'b1, 4'b0101, 4'b0101, 1'b1, 4'b0100, 3'd3, 1'b0};
      vecs[19] = '{1'b0, 1'b0, 1'b1, 4'b0101, 4'b0101, 1'b1, 4'b1000, 3'd2, 1'b0};
      vecs[20] = '{1'b0, 1'b0, 1'b1, 4'b0101, 4'b0101, 1'b1, 4'b0001, 3'd1, 1'b0};
      vecs[21] = '{1'b0, 1'b0, 1'b1, 4'b0101, 4'b0101, 1'b0, 4'b0000, 3'd0, 1'b0};

      tick();
      for (int i = 0; i < 22; i++) begin
         applyStimulus(vecs[i].rst, vecs[i].clr, vecs[i].ready, vecs[i].a);
         checkOutput($sformatf("v%0d b", i), b, vecs[i].exp_b);
         checkOutput($sformatf("v%0d valid", i), evt_valid, vecs[i].exp_valid);
         checkOutput($sformatf("v%0d level", i), evt_level, vecs[i].exp_level);
         checkOutput($sformatf("v%0d overflow", i), overflow, vecs[i].exp_ovf);
         if (vecs[i].exp_valid) begin
            checkOutput($sformatf("v%0d mask", i), evt_mask, vecs[i].exp_mask);
         end
      end

      // Saturation of a 2-bit counter, then clr racing a toggle
      applyStimulus(1'b1, 1'b0, 1'b1, 4'b0000);
      checkOutput("cnt reset", cnt_flat, 8'h00);
      applyStimulus(1'b0, 1'b0, 1'b1, 4'b0001);
      applyStimulus(1'b0, 1'b0, 1'b1, 4'b0000);
      checkOutput("cnt two toggles", cnt_flat, expCnt(8'h02));
      applyStimulus(1'b0, 1'b0, 1'b1, 4'b0001);
      applyStimulus(1'b0, 1'b0, 1'b1, 4'b0000);
      applyStimulus(1'b0, 1'b0, 1'b1, 4'b0001);
      checkOutput("cnt saturated", cnt_flat, expCnt(8'h03));
      applyStimulus(1'b0, 1'b1, 1'b1, 4'b0000);
      checkOutput("cnt clr wins", cnt_flat, 8'h00);
      checkOutput("clr keeps b", b, 4'b0000);
      applyStimulus(1'b0, 1'b0, 1'b1, 4'b0001);
      checkOutput("cnt after clr", cnt_flat, expCnt(8'h01));

      // Reset with entries queued and counters non-zero
      applyStimulus(1'b1, 1'b0, 1'b0, 4'b0000);
      applyStimulus(1'b0, 1'b0, 1'b0, 4'b0011);
      checkOutput("two ch cnt", cnt_flat, expCnt(8'h05));
      applyStimulus(1'b0, 1'b0, 1'b0, 4'b0001);
      checkOutput("queued level", evt_level, 3'd2);
      checkOutput("queued cnt", cnt_flat, expCnt(8'h09));
      applyStimulus(1'b1, 1'b0, 1'b0, 4'b0001);
      checkOutput("rst valid", evt_valid, 1'b0);
      checkOutput("rst level", evt_level, 3'd0);
      checkOutput("rst cnt", cnt_flat, 8'h00);
      checkOutput("rst b", b, 4'b0000);
      applyStimulus(1'b0, 1'b0, 1'b0, 4'b0001);
      checkOutput("post rst valid", evt_valid, 1'b1);
      checkOutput("post rst mask", evt_mask, 4'b0001);
      checkOutput("post rst level", evt_level, 3'd1);

      // Drop coinciding with clr must not raise overflow
      applyStimulus(1'b0, 1'b0, 1'b0, 4'b0000);
      applyStimulus(1'b0, 1'b0, 1'b0, 4'b0001);
      applyStimulus(1'b0, 1'b0, 1'b0, 4'b0000);
      checkOutput("refill level", evt_level, 3'd4);
      applyStimulus(1'b0, 1'b1, 1'b0, 4'b0001);
      checkOutput("clr vs drop ovf", overflow, 1'b0);
      checkOutput("clr vs drop level", evt_level, 3'd4);
      applyStimulus(1'b0, 1'b0, 1'b0, 4'b0000);
      checkOutput("drop ovf", overflow, 1'b1);
      checkOutput("drop cnt", cnt_flat, expCnt(8'h01));

      // Inverted instance with a held constant
      a_i   = 4'b0011;
      rst_i = 1'b1;
      tick();
      checkOutput("inv reset b", b_i, 4'b1111);
      checkOutput("inv reset valid", valid_i, 1'b0);
      rst_i = 1'b0;
      tick();
      checkOutput("inv b", b_i, 4'b1100);
      checkOutput("inv valid", valid_i, 1'b1);
      checkOutput("inv mask", mask_i, 4'b0011);
      checkOutput("inv level", level_i, 3'd1);
      ready_i = 1'b1;
      tick();
      checkOutput("inv popped", valid_i, 1'b0);
      tick();
      tick();
      checkOutput("inv no more", valid_i, 1'b0);
      checkOutput("inv level idle", level_i, 3'd0);
      checkOutput("inv b held", b_i, 4'b1100);

      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end

endmodule
